// File: rtl/uart_rx_axis.sv
// UART 8N1 receive stage with an AXI4-Stream master output.
// The serial line is synchronised, framed by a down-counting bit timer
// and delivered one byte at a time with single-byte buffering.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a low on rxd_s while armed
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling 8 data bits, LSB first, one bit period apart
// STOP  | timing to the middle of the stop bit, then deliver or flag
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           prescale,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t                state, state_next;
  logic                  rxd_m, rxd_s;
  logic                  armed;
  logic [15:0]           presc_eff;
  logic [15:0]           presc_r;
  logic [18:0]           cnt;
  logic [2:0]            bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tick;
  logic                  start_det;
  logic                  bit_sample;
  logic                  byte_done;
  logic                  frame_bad;

  // A prescale of zero would stall the timer, so it runs as one.
  assign presc_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  assign tick      = (cnt == 19'd0);
  assign rx_busy   = (state != IDLE);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    bit_sample = 1'b0;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !rxd_s) begin
          start_det  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (tick) state_next = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          bit_sample = 1'b1;
          if (bit_idx == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          if (rxd_s) byte_done = 1'b1;
          else       frame_bad = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timer (down-counter reloaded on terminal count), bit index and shifter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_r <= 16'd1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (start_det) begin
        presc_r <= presc_eff;
        // First sample lands mid start bit, half a bit period after detection.
        cnt     <= {1'b0, presc_eff, 2'b00} - 19'd1;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        if (tick) cnt <= {presc_r, 3'b000} - 19'd1;
        else      cnt <= cnt - 19'd1;
      end
      if (bit_sample) begin
        shreg   <= {rxd_s, shreg[DATA_WIDTH-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // After a framing error (e.g. a break) stay disarmed until the line is seen high.
  always_ff @(posedge clk) begin
    if (!rst)                       armed <= 1'b0;
    else if (frame_bad)             armed <= 1'b0;
    else if (state == IDLE && rxd_s) armed <= 1'b1;
  end

  // Output holding register, handshake and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_axis_tdata     <= '0;
      m_axis_tvalid    <= 1'b0;
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= 1'b0;
    end else begin
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= frame_bad;
      if (byte_done) begin
        m_axis_tdata     <= shreg;
        m_axis_tvalid    <= 1'b1;
        rx_overrun_error <= m_axis_tvalid && !m_axis_tready;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
